sp_rx_lock_ctrl: RTL and testbench

//  Symbol-lock controller for the serial-parallel path. Shifts a 1-bit-per-clk serial stream (MSB first),

---
 rtl/sp_rx_lock_ctrl.sv | 135 +++++++++++++
 tb/tb_sp_rx_lock_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sp_rx_lock_ctrl.sv
// Symbol-lock controller: shifts a MSB-first serial stream, aligns on the comma
// symbol, declares lock after repeated aligned commas and delivers aligned bytes.
module sp_rx_lock_ctrl #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  IDL_SYM    = 8'h7C,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       IDLE_out,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT4 = 4'(LOSS_COUNT);

  state_t      state, state_nxt;
  logic [7:0]  shift_p0;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [3:0]  com_cnt, com_cnt_nxt;
  logic [3:0]  err_cnt, err_cnt_nxt;
  logic [3:0]  com_inc, err_inc;
  logic [7:0]  data_nxt;
  logic        valid_nxt, idle_nxt, lost_nxt;
  logic        boundary, is_com;

  function automatic logic is_idle_sym(input logic [7:0] sym);
    return (sym == COM_SYM) || (sym == IDL_SYM);
  endfunction

  assign boundary = (bit_cnt == 3'd0);
  assign is_com   = (shift_p0 == COM_SYM);
  assign com_inc  = com_cnt + 4'd1;
  assign err_inc  = err_cnt + 4'd1;
  assign active   = (state == LOCKED);

  // Stage p0: serial shift register and all control/output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEARCH;
      shift_p0  <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      err_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      IDLE_out  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_p0  <= {shift_p0[6:0], serial_in};
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      err_cnt   <= err_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      IDLE_out  <= idle_nxt;
      lock_lost <= lost_nxt;
    end
  end

  // Decisions use the pre-edge shift register contents
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt + 3'd1;
    com_cnt_nxt = com_cnt;
    err_cnt_nxt = err_cnt;
    data_nxt    = data_out;
    valid_nxt   = 1'b0;
    idle_nxt    = IDLE_out;
    lost_nxt    = 1'b0;
    unique case (state)
      SEARCH: begin
        bit_cnt_nxt = 3'd0;
        if (is_com) begin
          state_nxt   = CHECK;
          bit_cnt_nxt = 3'd1;
          com_cnt_nxt = 4'd1;
        end
      end
      CHECK: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_nxt = com_inc;
            if (com_inc == LOCK_CNT4) begin
              state_nxt   = LOCKED;
              err_cnt_nxt = 4'd0;
            end
          end else begin
            state_nxt   = SEARCH;
            com_cnt_nxt = 4'd0;
            bit_cnt_nxt = 3'd0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          data_nxt  = shift_p0;
          valid_nxt = 1'b1;
          idle_nxt  = is_idle_sym(shift_p0);
          if (is_com) err_cnt_nxt = 4'd0;
        end else if (is_com) begin
          // comma off the symbol boundary: count towards loss of lock
          err_cnt_nxt = err_inc;
          if (err_inc == LOSS_CNT4) begin
            state_nxt   = SEARCH;
            lost_nxt    = 1'b1;
            idle_nxt    = 1'b0;
            com_cnt_nxt = 4'd0;
            err_cnt_nxt = 4'd0;
            bit_cnt_nxt = 3'd0;
          end
        end
      end
      default: begin
        state_nxt   = SEARCH;
        bit_cnt_nxt = 3'd0;
        com_cnt_nxt = 4'd0;
        err_cnt_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sp_rx_lock_ctrl.sv
// Bench for sp_rx_lock_ctrl: directed lock/loss scenarios plus a randomized symbol
// stream, compared every cycle against an anchor-based behavioural model.
module tb_sp_rx_lock_ctrl;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, active, IDLE_out, lock_lost;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sp_rx_lock_ctrl #(
    .COM_SYM(COM), .IDL_SYM(IDL), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)
  ) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .data_out(data_out),
    .valid_out(valid_out), .active(active), .IDLE_out(IDLE_out), .lock_lost(lock_lost)
  );

  // Behavioural model: alignment is an anchor edge; symbol boundaries are every
  // 8th edge after it. hist holds the last eight received bits.
  logic [7:0] m_hist = '0;
  logic [7:0] m_data = '0;
  bit         m_aligned = 0, m_locked = 0, m_valid = 0, m_idle = 0, m_lost = 0;
  int         m_good = 0, m_bad = 0, m_edge = 0, m_anchor = 0;

  always @(posedge clk) begin
    logic [7:0] win;
    bit bnd;
    m_edge++;
    if (!reset) begin
      m_hist = '0; m_data = '0; m_aligned = 0; m_locked = 0;
      m_valid = 0; m_idle = 0; m_lost = 0; m_good = 0; m_bad = 0;
    end else begin
      win = m_hist;
      m_valid = 0;
      m_lost = 0;
      bnd = m_aligned && (((m_edge - m_anchor) % 8) == 0);
      if (!m_aligned) begin
        if (win == COM) begin m_aligned = 1; m_anchor = m_edge; m_good = 1; end
      end else if (!m_locked) begin
        if (bnd) begin
          if (win == COM) begin
            m_good++;
            if (m_good == LOCK_N) begin m_locked = 1; m_bad = 0; end
          end else begin
            m_aligned = 0; m_good = 0;
          end
        end
      end else begin
        if (bnd) begin
          m_data = win; m_valid = 1;
          m_idle = (win == COM) || (win == IDL);
          if (win == COM) m_bad = 0;
        end else if (win == COM) begin
          m_bad++;
          if (m_bad == LOSS_N) begin
            m_locked = 0; m_aligned = 0; m_good = 0; m_bad = 0;
            m_lost = 1; m_idle = 0;
          end
        end
      end
      m_hist = {m_hist[6:0], serial_in};
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({data_out, valid_out, active, IDLE_out, lock_lost} !==
        {m_data, m_valid, m_locked, m_idle, m_lost}) begin
      errors++;
      $display("FAIL outputs @%0t: got data=%02h v=%b a=%b idle=%b lost=%b, expected data=%02h v=%b a=%b idle=%b lost=%b",
               $time, data_out, valid_out, active, IDLE_out, lock_lost,
               m_data, m_valid, m_locked, m_idle, m_lost);
    end
  end

  // Per-test event log of observed outputs, checked against literal expectations
  int   ecnt, first_active, lost_n;
  int   v_edge[$];
  logic [7:0] v_data[$];
  logic v_idle[$];

  task automatic clear_log();
    ecnt = 0; first_active = -1; lost_n = 0;
    v_edge.delete(); v_data.delete(); v_idle.delete();
  endtask

  task automatic lit(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b);
    reset = r;
    serial_in = b;
    @(posedge clk);
    #1;
    ecnt++;
    if (active && first_active < 0) first_active = ecnt;
    if (valid_out) begin
      v_edge.push_back(ecnt); v_data.push_back(data_out); v_idle.push_back(IDLE_out);
    end
    if (lock_lost) lost_n++;
  endtask

  task automatic send_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) step(1'b1, s[i]);
  endtask

  task automatic send_n(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) send_sym(s);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0);
    clear_log();
  endtask

  initial begin
    #1;
    // T1: reset with random serial data
    clear_log();
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom));
    lit("t1_data", data_out, 0);
    lit("t1_flags", {valid_out, active, IDLE_out, lock_lost}, 0);
    clear_log();

    // T2: clean lock, then idle traffic
    send_n(COM, 4); send_n(IDL, 4); send_n(8'h00, 2);
    lit("t2_active_edge", first_active, 33);
    lit("t2_valid_count_ge4", (v_edge.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < v_edge.size(); i++) begin
      lit("t2_valid_edge", v_edge[i], 41 + 8 * i);
      lit("t2_data", v_data[i], 8'h7C);
      lit("t2_idle", v_idle[i], 1);
    end

    // T3: three stray bits shift the lock by three edges
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    send_n(COM, 4); send_n(IDL, 4); send_n(8'h00, 1);
    lit("t3_active_edge", first_active, 36);
    lit("t3_valid_count_ge4", (v_edge.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < v_edge.size(); i++) begin
      lit("t3_valid_edge", v_edge[i], 44 + 8 * i);
      lit("t3_data", v_data[i], 8'h7C);
    end

    // T4: a non-comma before lock sends the controller back to search
    do_reset();
    send_n(COM, 3); send_sym(8'h55); send_n(8'h00, 3);
    lit("t4_never_active", first_active, -1);
    lit("t4_no_valid", v_edge.size(), 0);

    // T5: misaligned commas drop lock, then relock on the new alignment
    do_reset();
    send_n(COM, 4); send_n(8'h3A, 2);
    step(1'b1, 1'b0);
    send_n(COM, 8); send_n(IDL, 3); send_n(8'h00, 2);
    lit("t5_lock_lost_pulses", lost_n, 1);
    lit("t5_relocked", active, 1);

    // T6: data symbol clears IDLE_out; reset mid-lock forces full reacquire
    do_reset();
    send_n(COM, 4); send_n(8'h3A, 2);
    lit("t6_valid_edge", (v_edge.size() > 0) ? v_edge[0] : -1, 41);
    lit("t6_data", (v_data.size() > 0) ? v_data[0] : 0, 8'h3A);
    lit("t6_idle", (v_idle.size() > 0) ? v_idle[0] : 1, 0);
    step(1'b0, 1'b1);
    lit("t6_rst_data", data_out, 0);
    lit("t6_rst_flags", {valid_out, active, IDLE_out, lock_lost}, 0);
    clear_log();
    send_n(COM, 4); send_n(IDL, 2);
    lit("t6_reacq_edge", first_active, 33);

    // Randomized stream: commas, idles, data, bit slips and occasional resets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 2) step(1'b0, 1'($urandom));
      else if (sel < 8) begin
        int k;
        k = $urandom_range(1, 7);
        for (int j = 0; j < k; j++) step(1'b1, 1'($urandom));
      end
      else if (sel < 50) send_sym(COM);
      else if (sel < 70) send_sym(IDL);
      else send_sym(8'($urandom));
    end

    step(1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
